// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the five-stage core and its hazard/sequencing controller.
// The core side uses modport master, pipe_ctrl uses modport slave.
interface pipe_ctrl_if #(
  parameter int STALL_CNT_W = 16
);
  logic                   ex_jump_en_i;
  logic [31:0]            ex_jump_addr_i;
  logic [4:0]             id_rs1_addr_i;
  logic [4:0]             id_rs2_addr_i;
  logic                   id_rs1_used_i;
  logic                   id_rs2_used_i;
  logic                   id_ex_load_i;
  logic [4:0]             id_ex_rd_addr_i;
  logic                   ex_mc_start_i;
  logic                   ex_mc_done_i;
  logic                   pc_jump_en_o;
  logic [31:0]            pc_jump_addr_o;
  logic                   hold_pc_o;
  logic                   hold_if_id_o;
  logic                   hold_id_ex_o;
  logic                   flush_if_id_o;
  logic                   flush_id_ex_o;
  logic                   ex_wen_mask_o;
  logic                   mc_err_o;
  logic [STALL_CNT_W-1:0] stall_cnt_o;
  logic [1:0]             state_o;

  modport master (
    output ex_jump_en_i, ex_jump_addr_i, id_rs1_addr_i, id_rs2_addr_i,
           id_rs1_used_i, id_rs2_used_i, id_ex_load_i, id_ex_rd_addr_i,
           ex_mc_start_i, ex_mc_done_i,
    input  pc_jump_en_o, pc_jump_addr_o, hold_pc_o, hold_if_id_o, hold_id_ex_o,
           flush_if_id_o, flush_id_ex_o, ex_wen_mask_o, mc_err_o, stall_cnt_o, state_o
  );

  modport slave (
    input  ex_jump_en_i, ex_jump_addr_i, id_rs1_addr_i, id_rs2_addr_i,
           id_rs1_used_i, id_rs2_used_i, id_ex_load_i, id_ex_rd_addr_i,
           ex_mc_start_i, ex_mc_done_i,
    output pc_jump_en_o, pc_jump_addr_o, hold_pc_o, hold_if_id_o, hold_id_ex_o,
           flush_if_id_o, flush_id_ex_o, ex_wen_mask_o, mc_err_o, stall_cnt_o, state_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/sequencing controller: jump flush, load-use bubble, multi-cycle EX freeze, stall counter.
// Define PIPE_CTRL_MC_TIMEOUT_EN to enable the MC_WAIT timeout counter and the sticky mc_err_o flag.
module pipe_ctrl #(
  parameter int MC_TIMEOUT  = 64,
  parameter int STALL_CNT_W = 16
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MC_WAIT = 2'd1
  } state_t;

  state_t                 state_r;
  logic [STALL_CNT_W-1:0] stall_cnt_r;
  logic                   mc_err_s;
  logic                   lu_s;
  logic                   timeout_s;
  logic                   enter_wait_s;
  logic                   pc_jump_en_s;
  logic [31:0]            pc_jump_addr_s;
  logic                   hold_pc_s;
  logic                   hold_if_id_s;
  logic                   hold_id_ex_s;
  logic                   flush_if_id_s;
  logic                   flush_id_ex_s;
  logic                   ex_wen_mask_s;

  if ((MC_TIMEOUT < 2) || (MC_TIMEOUT > 65535)) begin : g_bad_mc_timeout
    $error("pipe_ctrl: MC_TIMEOUT must lie in 2..65535");
  end

  assign lu_s = bus.id_ex_load_i && (bus.id_ex_rd_addr_i != 5'd0) &&
                ((bus.id_rs1_used_i && (bus.id_rs1_addr_i == bus.id_ex_rd_addr_i)) ||
                 (bus.id_rs2_used_i && (bus.id_rs2_addr_i == bus.id_ex_rd_addr_i)));

  // A jump in EX outranks a multi-cycle start, so the wait is entered only without one.
  assign enter_wait_s = (state_r == ST_RUN) && !bus.ex_jump_en_i &&
                        bus.ex_mc_start_i && !bus.ex_mc_done_i;

`ifdef PIPE_CTRL_MC_TIMEOUT_EN
  logic [15:0] mc_cnt_r;
  logic        mc_err_r;

  assign timeout_s = (state_r == ST_MC_WAIT) && !bus.ex_mc_done_i &&
                     (mc_cnt_r == 16'(MC_TIMEOUT - 1));
  assign mc_err_s  = mc_err_r;

  // Wait-cycle counter (restarts on each entry) and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mc_cnt_r <= 16'd0;
      mc_err_r <= 1'b0;
    end else begin
      if (enter_wait_s) begin
        mc_cnt_r <= 16'd0;
      end else if ((state_r == ST_MC_WAIT) && !bus.ex_mc_done_i) begin
        mc_cnt_r <= mc_cnt_r + 16'd1;
      end else begin
        mc_cnt_r <= mc_cnt_r;
      end
      if (timeout_s) begin
        mc_err_r <= 1'b1;
      end else begin
        mc_err_r <= mc_err_r;
      end
    end
  end
`else
  assign timeout_s = 1'b0;
  assign mc_err_s  = 1'b0;
`endif

  // State register: RUN <-> MC_WAIT.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_RUN;
    end else begin
      case (state_r)
        ST_RUN:     state_r <= enter_wait_s ? ST_MC_WAIT : ST_RUN;
        ST_MC_WAIT: state_r <= (bus.ex_mc_done_i || timeout_s) ? ST_RUN : ST_MC_WAIT;
        default:    state_r <= ST_RUN;
      endcase
    end
  end

  // Stall performance counter, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_r <= '0;
    end else if (hold_pc_s && (stall_cnt_r != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  // Same-cycle control decode; everything is forced inactive (write mask closed) during reset.
  always_comb begin
    pc_jump_en_s   = 1'b0;
    pc_jump_addr_s = 32'h0000_0000;
    hold_pc_s      = 1'b0;
    hold_if_id_s   = 1'b0;
    hold_id_ex_s   = 1'b0;
    flush_if_id_s  = 1'b0;
    flush_id_ex_s  = 1'b0;
    ex_wen_mask_s  = 1'b1;
    if (!rst) begin
      ex_wen_mask_s = 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (bus.ex_jump_en_i) begin
            pc_jump_en_s   = 1'b1;
            pc_jump_addr_s = bus.ex_jump_addr_i;
            flush_if_id_s  = 1'b1;
            flush_id_ex_s  = 1'b1;
          end else if (bus.ex_mc_start_i && !bus.ex_mc_done_i) begin
            hold_pc_s     = 1'b1;
            hold_if_id_s  = 1'b1;
            hold_id_ex_s  = 1'b1;
            ex_wen_mask_s = 1'b0;
          end else if (!bus.ex_mc_start_i && lu_s) begin
            hold_pc_s     = 1'b1;
            hold_if_id_s  = 1'b1;
            flush_id_ex_s = 1'b1;
          end else begin
            ex_wen_mask_s = 1'b1;
          end
        end
        ST_MC_WAIT: begin
          if (bus.ex_mc_done_i) begin
            ex_wen_mask_s = 1'b1;
          end else if (timeout_s) begin
            ex_wen_mask_s = 1'b0;
            flush_id_ex_s = 1'b1;
          end else begin
            hold_pc_s     = 1'b1;
            hold_if_id_s  = 1'b1;
            hold_id_ex_s  = 1'b1;
            ex_wen_mask_s = 1'b0;
          end
        end
        default: begin
          ex_wen_mask_s = 1'b1;
        end
      endcase
    end
  end

  assign bus.pc_jump_en_o   = pc_jump_en_s;
  assign bus.pc_jump_addr_o = pc_jump_addr_s;
  assign bus.hold_pc_o      = hold_pc_s;
  assign bus.hold_if_id_o   = hold_if_id_s;
  assign bus.hold_id_ex_o   = hold_id_ex_s;
  assign bus.flush_if_id_o  = flush_if_id_s;
  assign bus.flush_id_ex_o  = flush_id_ex_s;
  assign bus.ex_wen_mask_o  = ex_wen_mask_s;
  assign bus.mc_err_o       = mc_err_s;
  assign bus.stall_cnt_o    = stall_cnt_r;
  assign bus.state_o        = rst ? state_r : ST_RUN;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios then randomized cycles against a behavioural model.
// Build with or without PIPE_CTRL_MC_TIMEOUT_EN; the model follows the same macro.
module tb_pipe_ctrl;
  localparam int MC_T      = 4;
  localparam int SW        = 4;
  localparam int STALL_MAX = (1 << SW) - 1;
`ifdef PIPE_CTRL_MC_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.STALL_CNT_W(SW)) bus ();
  pipe_ctrl #(.MC_TIMEOUT(MC_T), .STALL_CNT_W(SW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  // Model: whether an op is waiting, which wait cycle (1-based) it is in, error flag, stall total.
  bit  m_wait;
  int  m_wc;
  bit  m_err;
  int  m_stall;
  logic        e_jump, e_hpc, e_hif, e_hex, e_fif, e_fex, e_wen;
  logic [31:0] e_addr;
  logic [1:0]  e_state;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_eval();
    bit lu;
    lu = bus.id_ex_load_i && (bus.id_ex_rd_addr_i != 5'd0) &&
         ((bus.id_rs1_used_i && (bus.id_rs1_addr_i == bus.id_ex_rd_addr_i)) ||
          (bus.id_rs2_used_i && (bus.id_rs2_addr_i == bus.id_ex_rd_addr_i)));
    {e_jump, e_hpc, e_hif, e_hex, e_fif, e_fex} = 6'b0;
    e_addr  = 32'h0;
    e_wen   = 1'b1;
    e_state = m_wait ? 2'd1 : 2'd0;
    if (!rst) begin
      e_wen   = 1'b0;
      e_state = 2'd0;
    end else if (m_wait) begin
      if (bus.ex_mc_done_i) e_wen = 1'b1;
      else if (TO_EN && (m_wc == MC_T)) begin e_wen = 1'b0; e_fex = 1'b1; end
      else begin {e_hpc, e_hif, e_hex} = 3'b111; e_wen = 1'b0; end
    end else if (bus.ex_jump_en_i) begin
      e_jump = 1'b1; e_addr = bus.ex_jump_addr_i; e_fif = 1'b1; e_fex = 1'b1;
    end else if (bus.ex_mc_start_i) begin
      if (!bus.ex_mc_done_i) begin {e_hpc, e_hif, e_hex} = 3'b111; e_wen = 1'b0; end
    end else if (lu) begin
      e_hpc = 1'b1; e_hif = 1'b1; e_fex = 1'b1;
    end
  endtask

  task automatic model_update();
    if (!rst) begin
      m_wait = 1'b0; m_wc = 0; m_err = 1'b0; m_stall = 0;
    end else begin
      if (e_hpc && (m_stall < STALL_MAX)) m_stall++;
      if (m_wait) begin
        if (bus.ex_mc_done_i) m_wait = 1'b0;
        else if (TO_EN && (m_wc == MC_T)) begin m_wait = 1'b0; m_err = 1'b1; end
        else m_wc++;
      end else if (!bus.ex_jump_en_i && bus.ex_mc_start_i && !bus.ex_mc_done_i) begin
        m_wait = 1'b1; m_wc = 1;
      end
    end
  endtask

  // One cycle: inputs already applied after a falling edge; check, then let the edge happen.
  task automatic step();
    model_eval();
    #1;
    chk("pc_jump_en",   32'(bus.pc_jump_en_o),  32'(e_jump));
    chk("pc_jump_addr", bus.pc_jump_addr_o,     e_addr);
    chk("hold_pc",      32'(bus.hold_pc_o),     32'(e_hpc));
    chk("hold_if_id",   32'(bus.hold_if_id_o),  32'(e_hif));
    chk("hold_id_ex",   32'(bus.hold_id_ex_o),  32'(e_hex));
    chk("flush_if_id",  32'(bus.flush_if_id_o), 32'(e_fif));
    chk("flush_id_ex",  32'(bus.flush_id_ex_o), 32'(e_fex));
    chk("ex_wen_mask",  32'(bus.ex_wen_mask_o), 32'(e_wen));
    chk("mc_err",       32'(bus.mc_err_o),      32'(m_err));
    chk("stall_cnt",    32'(bus.stall_cnt_o),   32'(m_stall));
    chk("state",        32'(bus.state_o),       32'(e_state));
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic clr();
    bus.ex_jump_en_i    = 1'b0;
    bus.ex_jump_addr_i  = 32'h0;
    bus.id_rs1_addr_i   = 5'd0;
    bus.id_rs2_addr_i   = 5'd0;
    bus.id_rs1_used_i   = 1'b0;
    bus.id_rs2_used_i   = 1'b0;
    bus.id_ex_load_i    = 1'b0;
    bus.id_ex_rd_addr_i = 5'd0;
    bus.ex_mc_start_i   = 1'b0;
    bus.ex_mc_done_i    = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rd);
    bus.id_ex_load_i = 1'b1; bus.id_ex_rd_addr_i = rd;
    bus.id_rs2_addr_i = 5'd5; bus.id_rs2_used_i = 1'b1;
  endtask

  initial begin
    clr();
    rst = 1'b0;
    m_wait = 1'b0; m_wc = 0; m_err = 1'b0; m_stall = 0;
    @(posedge clk);
    @(negedge clk);
    step();
    rst = 1'b1;
    step();
    // Jump redirect.
    bus.ex_jump_en_i = 1'b1; bus.ex_jump_addr_i = 32'h0000_0100;
    step();
    clr();
    // Load-use bubble, then the same with rd = x0.
    set_lu(5'd5);
    step();
    chk("lu_stall_cnt", 32'(bus.stall_cnt_o), 32'd1);
    set_lu(5'd0);
    step();
    chk("lu_x0_stall_cnt", 32'(bus.stall_cnt_o), 32'd1);
    clr();
    // Multi-cycle op finishing on the third wait cycle.
    bus.ex_mc_start_i = 1'b1;
    step(); step(); step();
    bus.ex_mc_done_i = 1'b1;
    step();
    chk("mc_stall_cnt", 32'(bus.stall_cnt_o), 32'd4);
    clr();
    step();
    // Jump, multi-cycle start and load-use together.
    bus.ex_jump_en_i = 1'b1; bus.ex_jump_addr_i = 32'hDEAD_BEE0;
    bus.ex_mc_start_i = 1'b1; set_lu(5'd5);
    step();
    chk("prio_state", 32'(bus.state_o), 32'd0);
    clr();
`ifdef PIPE_CTRL_MC_TIMEOUT_EN
    bus.ex_mc_start_i = 1'b1;
    for (int i = 0; i < 1 + MC_T; i++) step();
    clr();
    step();
    chk("timeout_err", 32'(bus.mc_err_o), 32'd1);
    chk("timeout_state", 32'(bus.state_o), 32'd0);
`else
    bus.ex_mc_start_i = 1'b1;
    for (int i = 0; i < 101; i++) step();
    #1;
    chk("hold_after_100", 32'(bus.hold_pc_o), 32'd1);
    bus.ex_mc_done_i = 1'b1;
    step();
    clr();
`endif
    // Reset while waiting with seven stall cycles accumulated.
    rst = 1'b0;
    step();
    rst = 1'b1;
    set_lu(5'd5);
    for (int i = 0; i < 5; i++) step();
    clr();
    bus.ex_mc_start_i = 1'b1;
    step(); step();
    chk("pre_rst_stall", 32'(bus.stall_cnt_o), 32'd7);
    chk("pre_rst_state", 32'(bus.state_o), 32'd1);
    rst = 1'b0;
    step();
    chk("post_rst_stall", 32'(bus.stall_cnt_o), 32'd0);
    chk("post_rst_err", 32'(bus.mc_err_o), 32'd0);
    rst = 1'b1;
    clr();
    step();
    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      bus.ex_jump_en_i    = ($urandom_range(7) == 0);
      bus.ex_jump_addr_i  = $urandom;
      bus.ex_mc_start_i   = m_wait ? 1'b1 : ($urandom_range(3) == 0);
      bus.ex_mc_done_i    = ($urandom_range(3) == 0);
      bus.id_ex_load_i    = 1'($urandom_range(1));
      bus.id_ex_rd_addr_i = 5'($urandom_range(3));
      bus.id_rs1_addr_i   = 5'($urandom_range(3));
      bus.id_rs2_addr_i   = 5'($urandom_range(3));
      bus.id_rs1_used_i   = 1'($urandom_range(1));
      bus.id_rs2_used_i   = 1'($urandom_range(1));
      rst                 = ($urandom_range(79) != 0);
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
